// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO: Gray/binary conversion and pointer sizing.
// Used by the read-side controller, the write-pointer block and the synchronizer top.
package fifo_pkg;

   // Widest pointer the conversion helpers handle; callers size-cast in and out.
   localparam int GRAY_MAX_W = 32;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   function automatic int ptr_width(input int addr_width);
      return addr_width + 1;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
      logic [GRAY_MAX_W-1:0] bin;
      bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB).
module gray_to_bin
   import fifo_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-side controller of the async FIFO: read pointers, empty flag, and a
// first-word-fall-through output register with a valid/ready handshake.
module fifo_rd_fwft
   import fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int FIFO_DEPTH = 8,
   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH),
   localparam int PTR_WIDTH  = ptr_width(ADDR_WIDTH)
) (
   input  logic                  R_CLK,
   input  logic                  R_RST,
   input  logic [PTR_WIDTH-1:0]  sync_gray_wptr,
   input  logic [DATA_WIDTH-1:0] R_data,
   output logic [ADDR_WIDTH-1:0] R_addr,
   output logic [PTR_WIDTH-1:0]  gray_rd_ptr,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PTR_WIDTH-1:0]  rd_level
);

   logic [PTR_WIDTH-1:0]  bn_rd_ptr_q, bn_rd_ptr_d;
   logic [PTR_WIDTH-1:0]  gray_rd_ptr_q, gray_rd_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_level_q, rd_level_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [PTR_WIDTH-1:0]  comb_gray_rptr;
   logic [PTR_WIDTH-1:0]  sync_bin_wptr;
   logic                  empty_int;
   logic                  fetch;
   out_state_e            out_state;

   gray_to_bin #(
      .WIDTH (PTR_WIDTH)
   ) u_wptr_g2b (
      .gray (sync_gray_wptr),
      .bin  (sync_bin_wptr)
   );

   // The output-register state is out_valid itself; no separate state flop.
   assign out_state = out_state_e'(out_valid_q);

   always_comb begin
      comb_gray_rptr = PTR_WIDTH'(bin2gray(GRAY_MAX_W'(bn_rd_ptr_q)));
      empty_int      = (comb_gray_rptr == sync_gray_wptr);
      fetch          = 1'b0;
      bn_rd_ptr_d    = bn_rd_ptr_q;
      out_data_d     = out_data_q;
      out_valid_d    = out_valid_q;

      case (out_state)
         OUT_EMPTY: begin
            fetch = !empty_int;
         end
         OUT_FULL: begin
            if (out_ready) begin
               fetch = !empty_int;
               if (empty_int) begin
                  out_valid_d = 1'b0;
               end
            end
         end
         default: begin
            fetch = 1'b0;
         end
      endcase

      if (fetch) begin
         out_data_d  = R_data;
         out_valid_d = 1'b1;
         bn_rd_ptr_d = bn_rd_ptr_q + PTR_WIDTH'(1);
      end

      gray_rd_ptr_d = comb_gray_rptr;
      // Write pointer is seen late, so this can only under-count.
      rd_level_d    = sync_bin_wptr - bn_rd_ptr_q;
   end

   always_ff @(posedge R_CLK or negedge R_RST) begin
      if (!R_RST) begin
         bn_rd_ptr_q   <= '0;
         gray_rd_ptr_q <= '0;
         rd_level_q    <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
      end else begin
         bn_rd_ptr_q   <= bn_rd_ptr_d;
         gray_rd_ptr_q <= gray_rd_ptr_d;
         rd_level_q    <= rd_level_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
      end
   end

   assign R_addr      = bn_rd_ptr_q[ADDR_WIDTH-1:0];
   assign gray_rd_ptr = gray_rd_ptr_q;
   assign empty       = empty_int;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign rd_level    = rd_level_q;

endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
- Read-side controller of the asynchronous FIFO, in the read clock domain. It is the counterpart downstream of the write-side pointer/full logic.
- Owns the binary and Gray read pointers and derives `empty` against the synchronized Gray write pointer.
- Prefetches the head word from the dual-port memory into an output register and presents it to the consumer with a first-word-fall-through valid/ready handshake.
- Also reports a registered occupancy estimate for flow-control/debug.

Parameters:
- DATA_WIDTH, 8, width of each FIFO word.
- FIFO_DEPTH, 8, number of memory entries; must be a power of two, ≥ 4.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), localparam; memory address width. Pointers are ADDR_WIDTH+1 bits.

Ports:
- R_CLK  input  1  read-domain clock; all state on rising edge.
- R_RST  input  1  asynchronous active-low reset (assert async, release synchronized upstream).
- sync_gray_wptr  input  ADDR_WIDTH+1  Gray write pointer after the 2-flop synchronizer into R_CLK.
- R_data  input  DATA_WIDTH  memory read data; combinational function of R_addr.
- R_addr  output  ADDR_WIDTH  memory read address = bn_rd_ptr[ADDR_WIDTH-1:0].
- gray_rd_ptr  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer.
- empty  output  1  memory holds no unread word (output register not counted).
- out_data  output  DATA_WIDTH  head word to consumer.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- rd_level  output  ADDR_WIDTH+1  registered count of words in memory, 0..FIFO_DEPTH.

Behaviour:
- Reset (R_RST=0, async):
  - bn_rd_ptr=0, gray_rd_ptr=0, out_data=0, out_valid=0, rd_level=0.
  - empty=1 whenever sync_gray_wptr==0.
- Gray conversion: comb_gray_rptr = bn_rd_ptr ^ (bn_rd_ptr>>1).
- empty = (comb_gray_rptr == sync_gray_wptr). Combinational, full-width compare.
- Fetch condition: fetch = !empty && (!out_valid || out_ready).
- On the R_CLK edge with fetch=1:
  - out_data <= R_data, out_valid <= 1.
  - bn_rd_ptr <= bn_rd_ptr+1, modulo 2^(ADDR_WIDTH+1).
- Else if out_valid && out_ready: out_valid <= 0, out_data holds its last value.
- Else: out_data and out_valid hold.
  - Stability rule: out_data must not change while out_valid=1 && out_ready=0.
- Simultaneous consume and fetch: back-to-back transfer, out_valid stays 1, new word loaded. Sustained throughput is 1 word/cycle.
- gray_rd_ptr <= comb_gray_rptr every cycle, one cycle after bn_rd_ptr.
- rd_level <= gray2bin(sync_gray_wptr) − bn_rd_ptr (mod 2^(ADDR_WIDTH+1)), registered every cycle.
  - Because the write pointer is seen late, rd_level is pessimistic: it may under-count, never over-count.
- Latency:
  - A word written at a write-side edge reaches sync_gray_wptr after the synchronizer (2 R_CLK).
  - out_valid rises on the next R_CLK edge after empty deasserts.
  - Zero-cycle bypass from out_ready to out_valid is not provided.
- Wrap-around: the pointer's MSB toggles at each pass through depth, so empty stays correct across wraps. After 2·FIFO_DEPTH reads, bn_rd_ptr returns to 0.
- Empty with out_valid=1 is legal: the last word is in the output register.
- Reset mid-operation: any word in the output register is discarded. out_valid drops immediately (async).
- Overflow/underflow: a read is never issued when empty. Protection against writes while full is the write side's responsibility.

Decomposition:
- Shared package fifo_pkg:
  - Function bin2gray(width-generic).
  - Function gray2bin (XOR-prefix from MSB).
  - Pointer-width helper PTR_WIDTH = ADDR_WIDTH+1.
  - Reused by the write-pointer block and the synchronizer top.
- One natural sub-module: gray_to_bin (parameterized WIDTH, combinational XOR-prefix), instantiated for the rd_level computation.
- The controller FSM is implicit: two states, OUT_EMPTY/OUT_FULL, encoded by out_valid; no separate state register.

Test Plan:
1. Reset check: hold R_RST=0, sync_gray_wptr=0 → empty=1, out_valid=0, R_addr=0, gray_rd_ptr=0, rd_level=0.
2. Single word:
   - Stimulus: sync_gray_wptr 0→1 (binary 1), R_data=8'hA5, out_ready=0.
   - Response: next edge out_valid=1, out_data=A5, R_addr=1, empty=1.
   - Then out_data stays A5 for 5 cycles while out_ready=0.
   - rd_level=0 after the fetch; gray_rd_ptr=1 one edge later.
3. Streaming:
   - Stimulus: sync_gray_wptr=Gray(6)=4'b0101, memory holds 0x10..0x15, out_ready=1 constantly.
   - Response: out_data takes 10,11,12,13,14,15 on consecutive cycles with out_valid continuous.
   - Then out_valid=0 one cycle after the last accept, empty=1.
4. Backpressure:
   - Stimulus: 4 words available, out_ready toggles 1,0,1,0.
   - Response: each word is delivered exactly once, in order. R_addr advances only on fetch cycles.
5. Wrap-around (FIFO_DEPTH=8):
   - Stimulus: push and pop 20 words.
   - Response: bn_rd_ptr passes 15→0, gray_rd_ptr goes 4'b1000→4'b0000, and no spurious empty=0 occurs at the wrap.
   - Data order is preserved.
6. Mid-operation reset:
   - Stimulus: with out_valid=1 and rd_level=3, pulse R_RST low.
   - Response: out_valid=0 and pointers=0 immediately; after release, empty follows sync_gray_wptr only.
